// File: rtl/mul_pipe_m2_pkg.sv
// Shared types for the pipelined multiplier: op encoding, default widths and sideband record.
package mul_pkg;

  typedef enum logic [1:0] {
    MUL    = 2'b00,
    MULH   = 2'b01,
    MULHSU = 2'b10,
    MULHU  = 2'b11
  } mul_op_e;

  localparam int unsigned MUL_DATA_W = 16;
  localparam int unsigned MUL_ADDR_W = 4;
  localparam int unsigned MUL_STAGES = 3;

  // Sideband travelling with each product at the default configuration
  typedef struct packed {
    mul_op_e                 op;
    logic                    neg;
    logic [MUL_ADDR_W-1:0]   tag;
    logic                    valid;
  } mul_side_t;

  function automatic logic op_a_signed(input mul_op_e op);
    return (op == MULH) || (op == MULHSU);
  endfunction

  function automatic logic op_b_signed(input mul_op_e op);
    return (op == MULH);
  endfunction

endpackage

// File: rtl/mul_pipe_m2_if.sv
// Request/result handshake bundle for mul_pipe_m2; the flush wire exists only with MUL_FLUSH_EN.
interface mul_pipe_m2_if #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ADDR_W = 4
);
  logic              call;
  logic              in_ready;
  logic [1:0]        operation_in;
  logic [ADDR_W-1:0] dest_addr_in;
  logic [DATA_W-1:0] data_in1;
  logic [DATA_W-1:0] data_in2;
  logic [DATA_W-1:0] data_out;
  logic [ADDR_W-1:0] dest_addr_out;
  logic              valid;
  logic              out_ready;
  logic              empty;
`ifdef MUL_FLUSH_EN
  logic              flush;

  modport master (
    output call, operation_in, dest_addr_in, data_in1, data_in2, out_ready, flush,
    input  in_ready, data_out, dest_addr_out, valid, empty
  );
  modport slave (
    input  call, operation_in, dest_addr_in, data_in1, data_in2, out_ready, flush,
    output in_ready, data_out, dest_addr_out, valid, empty
  );
`else
  modport master (
    output call, operation_in, dest_addr_in, data_in1, data_in2, out_ready,
    input  in_ready, data_out, dest_addr_out, valid, empty
  );
  modport slave (
    input  call, operation_in, dest_addr_in, data_in1, data_in2, out_ready,
    output in_ready, data_out, dest_addr_out, valid, empty
  );
`endif
endinterface

// File: rtl/mul_pipe_m2_core_pipe.sv
// Unsigned W x W multiply followed by DEPTH register stages; sideband and valid ride alongside.
module mul_core_pipe #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned DEPTH  = 1,
  parameter int unsigned SIDE_W = 1
) (
  input  logic                  clk,
  input  logic                  sync_rst,
  input  logic                  clr,
  input  logic                  en,
  input  logic                  vld_in,
  input  logic [DATA_W-1:0]     a,
  input  logic [DATA_W-1:0]     b,
  input  logic [SIDE_W-1:0]     side_in,
  output logic                  vld_out,
  output logic [2*DATA_W-1:0]   prod_out,
  output logic [SIDE_W-1:0]     side_out,
  output logic                  busy_c
);
  localparam int unsigned PW = 2 * DATA_W;

  logic [PW-1:0]     prod_q [DEPTH];
  logic [SIDE_W-1:0] side_q [DEPTH];
  logic [DEPTH-1:0]  vld_q;
  logic [PW-1:0]     prod_c;

  assign prod_c = PW'(a) * PW'(b);

  // Product is formed in the first stage; later stages only delay it for retiming
  always_ff @(posedge clk) begin
    if (sync_rst) begin
      vld_q <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        prod_q[i] <= '0;
        side_q[i] <= '0;
      end
    end else if (clr) begin
      vld_q <= '0;
    end else if (en) begin
      vld_q[0]  <= vld_in;
      prod_q[0] <= prod_c;
      side_q[0] <= side_in;
      for (int i = 1; i < int'(DEPTH); i++) begin
        vld_q[i]  <= vld_q[i-1];
        prod_q[i] <= prod_q[i-1];
        side_q[i] <= side_q[i-1];
      end
    end
  end

  assign vld_out  = vld_q[DEPTH-1];
  assign prod_out = prod_q[DEPTH-1];
  assign side_out = side_q[DEPTH-1];
  assign busy_c   = |vld_q;

endmodule

// File: rtl/mul_pipe_m2.sv
// Pipelined RISC-style multiplier (MUL/MULH/MULHSU/MULHU) with valid/ready backpressure.
// Optional pipeline flush port is built when MUL_FLUSH_EN is defined.
module mul_pipe_m2
  import mul_pkg::*;
#(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ADDR_W = 4,
  parameter int unsigned STAGES = 3
) (
  input logic           clk,
  input logic           sync_rst,
  input logic           clk_en,
  mul_pipe_m2_if.slave  bus
);
  localparam int unsigned PW    = 2 * DATA_W;
  localparam int unsigned DEPTH = STAGES - 2;

  typedef struct packed {
    mul_op_e           op;
    logic              neg;
    logic [ADDR_W-1:0] tag;
  } side_t;

  localparam int unsigned SIDE_W = $bits(side_t);

  logic              flush_c;
  logic              adv_c;
  logic              clr_c;
  mul_op_e           op_c;
  logic              a_neg_c;
  logic              b_neg_c;
  logic [DATA_W-1:0] mag_a_c;
  logic [DATA_W-1:0] mag_b_c;

  logic              s1_vld_q;
  side_t             s1_side_q;
  logic [DATA_W-1:0] s1_a_q;
  logic [DATA_W-1:0] s1_b_q;

  logic              core_vld;
  logic [PW-1:0]     core_prod;
  side_t             core_side;
  logic              core_busy_c;

  logic [PW-1:0]     p_c;
  logic [DATA_W-1:0] res_c;

  logic              valid_q;
  logic [DATA_W-1:0] data_out_q;
  logic [ADDR_W-1:0] tag_out_q;

`ifdef MUL_FLUSH_EN
  assign flush_c = bus.flush;
`else
  assign flush_c = 1'b0;
`endif

  // Whole pipe moves as one; a stalled output stage freezes every stage behind it
  assign adv_c        = clk_en & (~valid_q | bus.out_ready);
  assign clr_c        = clk_en & flush_c;
  assign bus.in_ready = adv_c & ~flush_c;

  // Operand adjust: sign detection and magnitude (most-negative value maps to itself as unsigned)
  always_comb begin
    op_c    = mul_op_e'(bus.operation_in);
    a_neg_c = 1'b0;
    b_neg_c = 1'b0;
    mag_a_c = bus.data_in1;
    mag_b_c = bus.data_in2;
    a_neg_c = bus.data_in1[DATA_W-1] & op_a_signed(op_c);
    b_neg_c = bus.data_in2[DATA_W-1] & op_b_signed(op_c);
    if (a_neg_c) mag_a_c = -bus.data_in1;
    if (b_neg_c) mag_b_c = -bus.data_in2;
  end

  always_ff @(posedge clk) begin
    if (sync_rst) begin
      s1_vld_q  <= 1'b0;
      s1_side_q <= '0;
      s1_a_q    <= '0;
      s1_b_q    <= '0;
    end else if (clr_c) begin
      s1_vld_q <= 1'b0;
    end else if (adv_c) begin
      s1_vld_q      <= bus.call;
      s1_side_q.op  <= op_c;
      s1_side_q.neg <= a_neg_c ^ b_neg_c;
      s1_side_q.tag <= bus.dest_addr_in;
      s1_a_q        <= mag_a_c;
      s1_b_q        <= mag_b_c;
    end
  end

  mul_core_pipe #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .SIDE_W (SIDE_W)
  ) u_core (
    .clk      (clk),
    .sync_rst (sync_rst),
    .clr      (clr_c),
    .en       (adv_c),
    .vld_in   (s1_vld_q),
    .a        (s1_a_q),
    .b        (s1_b_q),
    .side_in  (s1_side_q),
    .vld_out  (core_vld),
    .prod_out (core_prod),
    .side_out (core_side),
    .busy_c   (core_busy_c)
  );

  // Sign fix and half select
  always_comb begin
    p_c   = core_prod;
    res_c = '0;
    if (core_side.neg) p_c = -core_prod;
    res_c = (core_side.op == MUL) ? p_c[DATA_W-1:0] : p_c[PW-1:DATA_W];
  end

  // Output data only loads on a real result, so bubbles leave the last value in place
  always_ff @(posedge clk) begin
    if (sync_rst) begin
      valid_q    <= 1'b0;
      data_out_q <= '0;
      tag_out_q  <= '0;
    end else if (clr_c) begin
      valid_q <= 1'b0;
    end else if (adv_c) begin
      valid_q <= core_vld;
      if (core_vld) begin
        data_out_q <= res_c;
        tag_out_q  <= core_side.tag;
      end
    end
  end

  assign bus.valid         = valid_q;
  assign bus.data_out      = data_out_q;
  assign bus.dest_addr_out = tag_out_q;
  assign bus.empty         = ~(s1_vld_q | core_busy_c | valid_q);

endmodule
